aes_iter_core: RTL and testbench
================================

// Module: aes_iter_core
// PURPOSE
//  Iterative AES (FIPS-197) block engine: encrypt or decrypt one 128-bit block per command.
//  Supports AES-128/192/256, selected per command by key word count nk.
//  Replaces the separate combinational Cipher/InverseCipher pair behind a start/done handshake.
//  Sits between the key/data wrappers and the block-mode logic.
// PARAMETERS
//  none (Nr derived from nk: 4->10, 6->12, 8->14)
// PORTS
//  clk      in   1    single clock; all state updates on rising edge
//  reset    in   1    synchronous, active-high
//  start    in   1    command strobe; accepted only when busy=0
//  decrypt  in   1    0 = Cipher, 1 = InverseCipher; latched at start
//  nk       in   4    key length in 32-bit words (4/6/8); latched at start
//  key      in   256  cipher key, right-aligned: AES-128 in key[127:0], AES-192 in key[191:0]
//  din      in   128  input block; byte0 = din[127:120], column-major state
//  dout     out  128  result block; valid from done, held until next accepted start
//  busy     out  1    high from cycle after start until done cycle inclusive
//  done     out  1    one-cycle pulse when dout is valid
// BEHAVIOUR
//  - Reset: dout=0, busy=0, done=0, FSM->IDLE, key store contents don't-care.
//    Reset mid-operation aborts; no done pulse is issued.
//  - nk not in {4,6,8} is treated as nk=4 (only the low 128 key bits used).
//  - FSM IDLE -> KEXP -> INIT -> ROUND -> IDLE.
//  - IDLE: on start, latch din/decrypt/nk, load w[0..nk-1] from key (w[0] = MS word of active key).
//  - KEXP: one word per cycle, w[i] = w[i-nk] ^ f(w[i-1]).
//    f = SubWord(RotWord)^Rcon when i%nk==0; SubWord when nk==8 and i%8==4; else identity.
//    Runs until 4*(Nr+1) words are stored (40/46/52 cycles).
//  - INIT: state = block ^ roundkey[0] for encrypt, roundkey[Nr] for decrypt (1 cycle).
//  - ROUND, one round per cycle, Nr cycles:
//    enc SubBytes, ShiftRows, MixColumns, AddRoundKey r=1..Nr;
//    dec InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns r=Nr-1..0.
//    MixColumns/InvMixColumns are omitted in the final round.
//  - Latency start->done = (4(Nr+1)-nk) + 1 + Nr cycles: 51 / 59 / 67.
//  - done pulses the cycle dout updates; busy drops the following cycle.
//    A start in that following cycle is accepted.
//  - start while busy is ignored, with no effect on the running command.
//  - Key store is rebuilt on every command; there is no key caching.
//  - GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; S-box = GF inverse (0->0) followed by affine 0x63.
// STRUCTURE
//  aes_pkg holds:
//    sbox()/inv_sbox() functions, xtime()/gmul(), Rcon table, Nr-from-nk function;
//    FSM state enum IDLE/KEXP/INIT/ROUND;
//    byte/word/state typedefs.
//  One sub-module, aes_round_comb: combinational full enc/dec round (state, roundkey, decrypt, last -> next).
//  Top holds the FSM, the 60x32 key store, counters and output registers.
// TESTING
//  - AES-128 enc: key=000102030405060708090a0b0c0d0e0f, din=00112233445566778899aabbccddeeff
//    -> dout=69c4e0d86a7b0430d8cdb78070b4c55a, done at start+51.
//  - AES-192 enc: key=000102030405060708090a0b0c0d0e0f1011121314151617, nk=6, same din
//    -> dda97ca4864cdfe06eaf70a0ec0d7191, done at start+59.
//  - AES-256 enc/dec: key=00..1f, nk=8, enc same din -> 8ea2b7ca516745bfeafc49904b496089 at +67;
//    decrypt of that result -> 00112233445566778899aabbccddeeff.
//  - Round trip: key=2b7e151628aed2a6abf7158809cf4f3c, din=6bc1bee22e409f96e93d7e117393172a
//    -> enc 3ad77bb40d7a3660a89ecaf32466ef97; decrypt returns din.
//    Repeat for random blocks at all nk.
//  - Handshake: start pulsed while busy is ignored; back-to-back start the cycle after busy
//    falls is accepted; reset mid-KEXP and mid-ROUND -> busy=0, done=0, dout=0, no late done.
//  - nk=5 behaves identically to nk=4 with key[127:0].

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM states and GF(2^8) helper functions
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} fsm_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // a^254 by repeated squaring; maps 0 to 0 as the S-box requires
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r, p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic byte_t rotl8(input byte_t x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic byte_t rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [3:0] nk);
        case (nk)
            4'd6:    return 4'd12;
            4'd8:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - combinational AES encrypt/decrypt round
module aes_round_comb
    import aes_pkg::*;
(
    input  block_t st,
    input  block_t rk,
    input  logic   decrypt,
    input  logic   last,
    output block_t nxt
);

    function automatic word_t mix_col(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic word_t inv_mix_col(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    block_t sub, keyed, mixed;

    always_comb begin
        sub = '0;
        // byte index 4*col+row; ShiftRows and InvShiftRows fold into the source column
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (decrypt)
                    sub[127 - 8*(4*c + r) -: 8] = inv_sbox(st[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
                else
                    sub[127 - 8*(4*c + r) -: 8] = sbox(st[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        keyed = decrypt ? (sub ^ rk) : sub;
        mixed = keyed;
        if (!last) begin
            for (int c = 0; c < 4; c++)
                mixed[127 - 32*c -: 32] = decrypt ? inv_mix_col(keyed[127 - 32*c -: 32])
                                                  : mix_col(keyed[127 - 32*c -: 32]);
        end
        nxt = decrypt ? mixed : (mixed ^ rk);
    end

endmodule

// File: rtl/aes_iter_core.sv
// rtl/aes_iter_core.sv - iterative AES-128/192/256 block engine with start/done handshake
module aes_iter_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         decrypt,
    input  logic [3:0]   nk,
    input  logic [255:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         busy,
    output logic         done
);

    fsm_t       fsm;
    word_t      w [60];
    logic [5:0] widx;
    logic [2:0] kpos;
    logic [3:0] rci, nk_q, nr_q, rnd;
    logic       dec_q;
    block_t     st;

    logic [3:0]   nk_in;
    logic [255:0] key_al;
    logic         accept, last;
    word_t        prev, old, f, wnew;
    logic [5:0]   wlast, kb;
    logic [3:0]   rk_sel;
    block_t       rk, rnext;

    assign nk_in  = (nk == 4'd6 || nk == 4'd8) ? nk : 4'd4;
    assign accept = (fsm == IDLE) && !busy && start;

    // left-justify the active key so w[j] is always the j-th word from the top
    always_comb begin
        case (nk_in)
            4'd8:    key_al = key;
            4'd6:    key_al = {key[191:0], 64'h0};
            default: key_al = {key[127:0], 128'h0};
        endcase
    end

    assign prev = w[widx - 6'd1];
    assign old  = w[widx - {2'b00, nk_q}];

    always_comb begin
        if (kpos == 3'd0)
            f = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(rci), 24'h0};
        else if (nk_q == 4'd8 && kpos == 3'd4)
            f = sub_word(prev);
        else
            f = prev;
    end

    assign wnew   = old ^ f;
    assign wlast  = {nr_q, 2'b00} + 6'd3;
    assign rk_sel = (fsm == INIT) ? (dec_q ? nr_q : 4'd0) : rnd;
    assign kb     = {rk_sel, 2'b00};
    assign rk     = {w[kb], w[kb + 6'd1], w[kb + 6'd2], w[kb + 6'd3]};
    assign last   = dec_q ? (rnd == 4'd0) : (rnd == nr_q);

    aes_round_comb u_round (
        .st      (st),
        .rk      (rk),
        .decrypt (dec_q),
        .last    (last),
        .nxt     (rnext)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 8; j++)
                w[j] <= key_al[255 - 32*j -: 32];
        end else if (fsm == KEXP) begin
            w[widx] <= wnew;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm   <= IDLE;
            dout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            widx  <= '0;
            kpos  <= '0;
            rci   <= '0;
            nk_q  <= 4'd4;
            nr_q  <= 4'd10;
            rnd   <= '0;
            dec_q <= 1'b0;
            st    <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy  <= 1'b1;
                        dec_q <= decrypt;
                        nk_q  <= nk_in;
                        nr_q  <= nr_of(nk_in);
                        st    <= din;
                        widx  <= {2'b00, nk_in};
                        kpos  <= '0;
                        rci   <= '0;
                        fsm   <= KEXP;
                    end
                end
                KEXP: begin
                    widx <= widx + 6'd1;
                    if ({1'b0, kpos} == nk_q - 4'd1) begin
                        kpos <= '0;
                        rci  <= rci + 4'd1;
                    end else begin
                        kpos <= kpos + 3'd1;
                    end
                    if (widx == wlast) fsm <= INIT;
                end
                INIT: begin
                    st  <= st ^ rk;
                    rnd <= dec_q ? (nr_q - 4'd1) : 4'd1;
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= rnext;
                    if (last) begin
                        dout <= rnext;
                        done <= 1'b1;
                        fsm  <= IDLE;
                    end else begin
                        rnd <= dec_q ? (rnd - 4'd1) : (rnd + 4'd1);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// tb/tb_aes_iter_core.sv - directed-vector bench for aes_iter_core
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         reset, start, decrypt;
    logic [3:0]   nk;
    logic [255:0] key;
    logic [127:0] din, dout;
    logic         busy, done;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t0 = 0;

    localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] K192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KSP  = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_core dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .decrypt (decrypt),
        .nk      (nk),
        .key     (key),
        .din     (din),
        .dout    (dout),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic dec, input logic [3:0] k_nk, input logic [255:0] k, input logic [127:0] blk);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin @(negedge clk); n++; end
        decrypt = dec; nk = k_nk; key = k; din = blk; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, output logic [127:0] res);
        int n = 0;
        while (!done && n < 120) begin @(posedge clk); #1; n++; end
        chk({tag, " done"}, 128'(done), 128'd1);
        chk({tag, " latency"}, 128'(cyc - t0), 128'(exp_lat));
        res = dout;
    endtask

    task automatic run(input string tag, input logic dec, input logic [3:0] k_nk, input logic [255:0] k,
                       input logic [127:0] blk, input int exp_lat, output logic [127:0] res);
        issue(dec, k_nk, k, blk);
        wait_done(tag, exp_lat, res);
    endtask

    task automatic quiet(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; if (done) pulses++; end
        chk({tag, " no late done"}, 128'(pulses), 128'd0);
    endtask

    initial begin
        logic [127:0] r, c, p, blk;
        logic [255:0] k;
        int lat [3] = '{51, 59, 67};
        logic [3:0] nks [3] = '{4'd4, 4'd6, 4'd8};

        reset = 1'b1; start = 1'b0; decrypt = 1'b0; nk = 4'd4; key = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", dout, 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        @(negedge clk); reset = 1'b0;

        run("aes128 enc", 1'b0, 4'd4, K128, PT, 51, r);
        chk("aes128 enc dout", r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("busy in done cycle", 128'(busy), 128'd1);
        @(posedge clk); #1;
        chk("busy after done", 128'(busy), 128'd0);

        run("aes192 enc", 1'b0, 4'd6, K192, PT, 59, r);
        chk("aes192 enc dout", r, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

        run("aes256 enc", 1'b0, 4'd8, K256, PT, 67, r);
        chk("aes256 enc dout", r, 128'h8ea2b7ca516745bfeafc49904b496089);
        // back-to-back: issue waits out the busy-drop cycle and strobes in the next one
        run("aes256 dec", 1'b1, 4'd8, K256, 128'h8ea2b7ca516745bfeafc49904b496089, 67, r);
        chk("aes256 dec dout", r, PT);

        run("sp enc", 1'b0, 4'd4, KSP, 128'h6bc1bee22e409f96e93d7e117393172a, 51, r);
        chk("sp enc dout", r, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
        run("sp dec", 1'b1, 4'd4, KSP, r, 51, p);
        chk("sp dec dout", p, 128'h6bc1bee22e409f96e93d7e117393172a);

        run("nk5 enc", 1'b0, 4'd5, {128'hdeadbeefcafef00d0123456789abcdef, K128[127:0]}, PT, 51, r);
        chk("nk5 enc dout", r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        run("aes128 back2back", 1'b1, 4'd4, K128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51, r);
        chk("aes128 dec dout", r, PT);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                blk = {$urandom(), $urandom(), $urandom(), $urandom()};
                run("rand enc", 1'b0, nks[i], k, blk, lat[i], c);
                run("rand dec", 1'b1, nks[i], k, c, lat[i], p);
                chk("rand roundtrip", p, blk);
            end
        end

        issue(1'b0, 4'd4, K128, PT);
        repeat (10) @(posedge clk);
        @(negedge clk);
        decrypt = 1'b1; nk = 4'd8; key = K256; din = 128'h0f0e0d0c0b0a09080706050403020100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("start while busy", 51, r);
        chk("start while busy dout", r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        quiet("start while busy", 80);

        issue(1'b0, 4'd4, K128, PT);
        repeat (20) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rst kexp busy", 128'(busy), 128'd0);
        chk("rst kexp done", 128'(done), 128'd0);
        chk("rst kexp dout", dout, 128'd0);
        @(negedge clk); reset = 1'b0;
        quiet("rst kexp", 80);

        issue(1'b0, 4'd8, K256, PT);
        repeat (57) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rst round busy", 128'(busy), 128'd0);
        chk("rst round done", 128'(done), 128'd0);
        chk("rst round dout", dout, 128'd0);
        @(negedge clk); reset = 1'b0;
        quiet("rst round", 80);

        run("after reset", 1'b0, 4'd6, K192, PT, 59, r);
        chk("after reset dout", r, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
